// File: rtl/snake_draw_sched_pkg.sv
// rtl/snake_draw_sched_pkg.sv - shared grid constants, colours, state encoding and cell helpers
package snake_pkg;

   localparam int GRID_W     = 40;
   localparam int GRID_H     = 30;
   localparam int CELL_SHIFT = 2;

   localparam logic [2:0] SNAKE_COLOUR_DEF = 3'b010;
   localparam logic [2:0] BG_COLOUR_DEF    = 3'b000;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_ERASE_GO   = 3'd1;
   localparam logic [2:0] ST_ERASE_WAIT = 3'd2;
   localparam logic [2:0] ST_DRAW_GO    = 3'd3;
   localparam logic [2:0] ST_DRAW_WAIT  = 3'd4;
   localparam logic [2:0] ST_FIN        = 3'd5;

   typedef struct packed {
      logic [5:0] gx;
      logic [4:0] gy;
   } cell_t;

   function automatic logic cell_in_range(input logic [5:0] gx, input logic [4:0] gy);
      return (gx < 6'(GRID_W)) && (gy < 5'(GRID_H));
   endfunction

   function automatic logic [7:0] cell_px_x(input logic [5:0] gx);
      return 8'(gx) << CELL_SHIFT;
   endfunction

   function automatic logic [6:0] cell_px_y(input logic [4:0] gy);
      return 7'(gy) << CELL_SHIFT;
   endfunction

endpackage

// File: rtl/snake_draw_sched_if.sv
// rtl/snake_draw_sched_if.sv - square-drawer job channel (go/done handshake)
interface snake_draw_sched_if;
   logic [7:0] sq_x;
   logic [6:0] sq_y;
   logic [2:0] sq_colour;
   logic       sq_go;
   logic       sq_done;

   modport master (
      output sq_x, sq_y, sq_colour, sq_go,
      input  sq_done
   );

   modport slave (
      input  sq_x, sq_y, sq_colour, sq_go,
      output sq_done
   );
endinterface

// File: rtl/snake_draw_sched_seg_ring.sv
// rtl/snake_draw_sched_seg_ring.sv - snake body ring buffer of grid cells
module seg_ring
   import snake_pkg::*;
#(
   parameter int MAX_LEN = 32,
   parameter int LW      = $clog2(MAX_LEN) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  cell_t         push_data,
   input  logic          pop,
   output cell_t         tail_data,
   output logic [LW-1:0] length
);

   localparam int PW = $clog2(MAX_LEN);

   cell_t         mem_q [MAX_LEN];
   logic [PW-1:0] head_ptr_q, head_ptr_d;
   logic [PW-1:0] tail_ptr_q, tail_ptr_d;
   logic [LW-1:0] length_q, length_d;

   // Power-of-two capacity lets the pointers wrap by plain overflow.
   always_comb begin
      head_ptr_d = head_ptr_q;
      tail_ptr_d = tail_ptr_q;
      length_d   = length_q;
      if (push) begin
         head_ptr_d = head_ptr_q + PW'(1);
         length_d   = length_q + LW'(1);
      end else if (pop) begin
         tail_ptr_d = tail_ptr_q + PW'(1);
         length_d   = length_q - LW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_ptr_q <= '0;
         tail_ptr_q <= '0;
         length_q   <= '0;
      end else begin
         head_ptr_q <= head_ptr_d;
         tail_ptr_q <= tail_ptr_d;
         length_q   <= length_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[head_ptr_q] <= push_data;
      end
   end

   assign tail_data = mem_q[tail_ptr_q];
   assign length    = length_q;

endmodule

// File: rtl/snake_draw_sched.sv
// rtl/snake_draw_sched.sv - move sequencer: erase old tail, draw new head via the square drawer
module snake_draw_sched
   import snake_pkg::*;
#(
   parameter int         MAX_LEN      = 32,
   parameter logic [2:0] SNAKE_COLOUR = SNAKE_COLOUR_DEF,
   parameter logic [2:0] BG_COLOUR    = BG_COLOUR_DEF,
   parameter int         LW           = $clog2(MAX_LEN) + 1
) (
   input  logic                      CLOCK_50,
   input  logic                      resetn,
   input  logic                      move_req,
   input  logic [5:0]                head_gx,
   input  logic [4:0]                head_gy,
   input  logic                      grow,
   snake_draw_sched_if.master        dr,
   output logic                      busy,
   output logic                      move_done,
   output logic                      range_err,
   output logic [LW-1:0]             length
);

   logic [2:0]    state_q, state_d;
   cell_t         head_q, head_d;
   logic [7:0]    sq_x_q, sq_x_d;
   logic [6:0]    sq_y_q, sq_y_d;
   logic [2:0]    sq_colour_q, sq_colour_d;
   logic          range_err_q, range_err_d;
   logic          push, pop, grow_eff;
   cell_t         tail_cell;
   logic [LW-1:0] len;

   seg_ring #(.MAX_LEN(MAX_LEN), .LW(LW)) u_ring (
      .clk       (CLOCK_50),
      .rst_n     (resetn),
      .push      (push),
      .push_data (head_q),
      .pop       (pop),
      .tail_data (tail_cell),
      .length    (len)
   );

   // An empty body has no tail to erase, so the first move always grows.
   assign grow_eff = (len == '0) || (grow && (len < LW'(MAX_LEN)));

   always_comb begin
      state_d     = state_q;
      head_d      = head_q;
      sq_x_d      = sq_x_q;
      sq_y_d      = sq_y_q;
      sq_colour_d = sq_colour_q;
      range_err_d = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (move_req) begin
               if (!cell_in_range(head_gx, head_gy)) begin
                  range_err_d = 1'b1;
               end else begin
                  head_d = '{gx: head_gx, gy: head_gy};
                  if (grow_eff) begin
                     state_d     = ST_DRAW_GO;
                     sq_x_d      = cell_px_x(head_gx);
                     sq_y_d      = cell_px_y(head_gy);
                     sq_colour_d = SNAKE_COLOUR;
                  end else begin
                     state_d     = ST_ERASE_GO;
                     sq_x_d      = cell_px_x(tail_cell.gx);
                     sq_y_d      = cell_px_y(tail_cell.gy);
                     sq_colour_d = BG_COLOUR;
                  end
               end
            end
         end
         ST_ERASE_GO: begin
            pop     = 1'b1;
            state_d = ST_ERASE_WAIT;
         end
         ST_ERASE_WAIT: begin
            if (dr.sq_done) begin
               state_d     = ST_DRAW_GO;
               sq_x_d      = cell_px_x(head_q.gx);
               sq_y_d      = cell_px_y(head_q.gy);
               sq_colour_d = SNAKE_COLOUR;
            end
         end
         ST_DRAW_GO: begin
            push    = 1'b1;
            state_d = ST_DRAW_WAIT;
         end
         ST_DRAW_WAIT: begin
            if (dr.sq_done) begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         head_q      <= '0;
         sq_x_q      <= '0;
         sq_y_q      <= '0;
         sq_colour_q <= '0;
         range_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         sq_x_q      <= sq_x_d;
         sq_y_q      <= sq_y_d;
         sq_colour_q <= sq_colour_d;
         range_err_q <= range_err_d;
      end
   end

   // Job coordinates are registered so they hold from go until the matching done.
   assign dr.sq_x      = sq_x_q;
   assign dr.sq_y      = sq_y_q;
   assign dr.sq_colour = sq_colour_q;
   assign dr.sq_go     = (state_q == ST_ERASE_GO) || (state_q == ST_DRAW_GO);
   assign busy         = (state_q != ST_IDLE);
   assign move_done    = (state_q == ST_FIN);
   assign range_err    = range_err_q;
   assign length       = len;

endmodule

// File: tb/tb_snake_draw_sched.sv
// tb/tb_snake_draw_sched.sv - randomized bench for snake_draw_sched against a queue-based body model
module tb_snake_draw_sched;
   localparam int MAX = 32;

   logic       CLOCK_50 = 1'b0;
   logic       resetn   = 1'b0;
   logic       move_req = 1'b0;
   logic [5:0] head_gx  = '0;
   logic [4:0] head_gy  = '0;
   logic       grow     = 1'b0;
   logic       busy, move_done, range_err;
   logic [5:0] length;

   snake_draw_sched_if dif();

   snake_draw_sched #(.MAX_LEN(MAX)) dut (
      .CLOCK_50  (CLOCK_50),
      .resetn    (resetn),
      .move_req  (move_req),
      .head_gx   (head_gx),
      .head_gy   (head_gy),
      .grow      (grow),
      .dr        (dif.master),
      .busy      (busy),
      .move_done (move_done),
      .range_err (range_err),
      .length    (length)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int n_cmp = 0;
   int n_err = 0;

   // Drawer stand-in: records each job, answers done after drv_lat extra cycles.
   logic [17:0] jobs[$];
   int          drv_lat = 0;
   int          cnt = 0;
   bit          pending = 0;
   bit          bad_stable = 0;
   bit          extra_go = 0;
   logic [17:0] lat_job;

   always @(negedge CLOCK_50) begin
      dif.sq_done = 1'b0;
      if (!resetn) begin
         pending = 0;
      end else if (pending) begin
         if ({dif.sq_x, dif.sq_y, dif.sq_colour} !== lat_job) bad_stable = 1;
         if (dif.sq_go) extra_go = 1;
         if (cnt == 0) begin
            dif.sq_done = 1'b1;
            pending = 0;
         end else begin
            cnt--;
         end
      end else if (dif.sq_go) begin
         lat_job = {dif.sq_x, dif.sq_y, dif.sq_colour};
         jobs.push_back(lat_job);
         cnt = drv_lat;
         pending = 1;
      end
   end

   logic [10:0] body[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      resetn = 1'b1;
      body.delete();
      jobs.delete();
   endtask

   task automatic do_move(input int gx, input int gy, input bit g, input int lat, input bit poke);
      bit          inr, ge, seen;
      int          cx, cy;
      logic [10:0] c;
      logic [17:0] exp_jobs[$];
      inr = (gx < 40) && (gy < 30);
      drv_lat = lat;
      jobs.delete();
      bad_stable = 0;
      extra_go = 0;
      @(negedge CLOCK_50);
      move_req = 1'b1;
      head_gx = gx[5:0];
      head_gy = gy[4:0];
      grow = g;
      @(negedge CLOCK_50);
      move_req = 1'b0;
      grow = 1'b0;
      check("range_err", range_err, !inr);
      check("busy_after_req", busy, inr);
      if (!inr) begin
         repeat (3) @(negedge CLOCK_50);
         check("range_no_job", jobs.size(), 0);
         check("range_len", length, body.size());
         return;
      end
      ge = (body.size() == 0) || (g && body.size() < MAX);
      if (!ge) begin
         c = body.pop_front();
         cx = c[10:5];
         cy = c[4:0];
         exp_jobs.push_back({8'(cx * 4), 7'(cy * 4), 3'b000});
      end
      exp_jobs.push_back({8'(gx * 4), 7'(gy * 4), 3'b010});
      body.push_back({gx[5:0], gy[4:0]});
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         move_req = poke && (i == 1);
         head_gx = 6'd0;
         head_gy = 5'd0;
         grow = poke;
         if (move_done) seen = 1;
         else @(negedge CLOCK_50);
      end
      move_req = 1'b0;
      grow = 1'b0;
      check("move_done_seen", seen, 1);
      @(negedge CLOCK_50);
      check("move_done_pulse", move_done, 0);
      check("idle_after", busy, 0);
      check("jobs_n", jobs.size(), exp_jobs.size());
      for (int j = 0; j < exp_jobs.size() && j < jobs.size(); j++)
         check($sformatf("job%0d", j), jobs[j], exp_jobs[j]);
      check("stable", bad_stable, 0);
      check("single_go", extra_go, 0);
      check("length", length, body.size());
   endtask

   initial begin
      #1;
      check("rst_go", dif.sq_go, 0);
      check("rst_busy", busy, 0);
      check("rst_len", length, 0);
      do_reset();
      check("rst_xyc", {dif.sq_x, dif.sq_y, dif.sq_colour}, 0);
      check("rst_flags", {move_done, range_err}, 0);

      do_move(5, 7, 0, 1, 0);
      check("first_job", jobs.size() > 0 ? jobs[0] : 18'h3ffff, {8'd20, 7'd28, 3'b010});

      do_reset();
      do_move(1, 1, 1, 0, 0);
      do_move(2, 1, 1, 2, 0);
      do_move(3, 1, 1, 1, 0);
      do_move(4, 1, 0, 2, 0);
      check("erase_job", jobs.size() > 0 ? jobs[0] : 18'h3ffff, {8'd4, 7'd4, 3'b000});
      do_move(5, 1, 1, 0, 1);
      check("grow_len4", length, 4);

      do_move(40, 0, 0, 0, 0);
      do_move(0, 30, 1, 0, 0);

      for (int k = 0; body.size() < MAX && k < 64; k++)
         do_move(k % 40, (k / 40) + 10, 1, 0, k % 3 == 0);
      check("full_len", length, MAX);
      for (int k = 0; k < 4; k++)
         do_move(39 - k, 29, 1, k, 0);
      check("full_len_kept", length, MAX);

      repeat (60)
         do_move($urandom_range(0, 45), $urandom_range(0, 31), $urandom_range(0, 1),
                 $urandom_range(0, 3), $urandom_range(0, 1));

      drv_lat = 20;
      @(negedge CLOCK_50);
      move_req = 1'b1;
      head_gx = 6'd3;
      head_gy = 5'd3;
      grow = 1'b0;
      @(negedge CLOCK_50);
      move_req = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      check("mid_busy", busy, 1);
      resetn = 1'b0;
      #1;
      check("mid_rst_go", dif.sq_go, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_len", length, 0);
      check("mid_rst_xyc", {dif.sq_x, dif.sq_y, dif.sq_colour}, 0);
      check("mid_rst_flags", {move_done, range_err}, 0);
      repeat (2) @(negedge CLOCK_50);
      resetn = 1'b1;
      body.delete();
      jobs.delete();
      do_move(9, 4, 0, 1, 0);
      check("post_rst_len", length, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
